calc_sequencer: RTL

Operand-entry and execution controller for the board-level calculator demo. It sits between the DIP/PB inputs and the SEVENSEGHEX/LED_OUT outputs of the Wrapper. It captures two 16-bit operands from DIP on push-button presses and executes the selected operation: ADD and SUB run in-block, and unsigned MUL is sequenced through the shared multi-cycle unit over a Start/Busy handshake.

---
 rtl/calc_pkg.sv | 24 ++
 rtl/pb_edge_detect.sv | 34 +++
 rtl/calc_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calculator sequencer.
`default_nettype none
package calc_pkg;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_EXEC    = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_WAIT    = 3'd4,
    ST_SHOW    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_t;

  localparam logic [1:0]  MC_OP_MULU  = 2'b01;
  localparam logic [31:0] ERR_PATTERN = 32'hDEAD_DEAD;

endpackage
`default_nettype wire

// File: rtl/pb_edge_detect.sv
// pb_edge_detect: 2-flop synchronizer followed by a registered rising-edge detector.
`default_nettype none
module pb_edge_detect #(
  parameter int W = 3
) (
  input  logic         CLK,
  input  logic         RESET_n,
  input  logic [W-1:0] i_pb,
  output logic [W-1:0] o_evt
);

  logic [W-1:0] r_sync1;
  logic [W-1:0] r_sync2;
  logic [W-1:0] r_prev;
  logic [W-1:0] r_evt;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_evt   <= '0;
    end else begin
      r_sync1 <= i_pb;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_evt   <= r_sync2 & ~r_prev;
    end
  end

  assign o_evt = r_evt;

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
// calc_sequencer: operand entry from DIP/PB, in-block ADD/SUB, MUL via the shared
// multi-cycle unit with a Busy watchdog.
`default_nettype none
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int N_DIPs     = 16,
  parameter int N_PBs      = 3,
  parameter int N_LEDs_OUT = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  CLK,
  input  logic                  RESET_n,
  input  logic [N_DIPs-1:0]     DIP,
  input  logic [N_PBs-1:0]      PB,
  output logic [31:0]           SEVENSEGHEX,
  output logic [N_LEDs_OUT-1:0] LED_OUT,
  output logic                  MC_Start,
  output logic [1:0]            MC_Op,
  output logic [31:0]           MC_Operand1,
  output logic [31:0]           MC_Operand2,
  input  logic [31:0]           MC_Result1,
  input  logic                  MC_Busy
);

  localparam int WD_W = $clog2(TIMEOUT) + 1;

  state_t            r_state;
  state_t            w_state_nxt;
  op_t               r_op;
  op_t               w_sel;
  logic [N_DIPs-1:0] r_a;
  logic [N_DIPs-1:0] r_b;
  logic [31:0]       r_res;
  logic              r_led0;
  logic              r_led1;
  logic [WD_W-1:0]   r_wdog;
  logic              r_seen_busy;
  logic [N_PBs-1:0]  w_evt;
  logic              w_any;
  logic              w_mc_done;
  logic              w_timeout;
  logic [N_DIPs:0]   w_sum;
  logic              w_led7;
  logic              w_led6;

  pb_edge_detect #(.W(N_PBs)) u_pb (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .i_pb    (PB),
    .o_evt   (w_evt)
  );

  assign w_any = |w_evt;
  assign w_sel = w_evt[2] ? OP_MUL : (w_evt[1] ? OP_SUB : OP_ADD);
  assign w_sum = (r_op == OP_SUB) ? ({1'b0, r_a} - {1'b0, r_b})
                                  : ({1'b0, r_a} + {1'b0, r_b});

  // Busy never raised by the second WAIT cycle means the unit finished instantly.
  assign w_mc_done = !MC_Busy && (r_seen_busy || (r_wdog >= WD_W'(1)));
  assign w_timeout = (r_wdog >= WD_W'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) r_state <= ST_ENTER_A;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ENTER_A: if (w_any) w_state_nxt = ST_ENTER_B;
      ST_ENTER_B: if (w_any) w_state_nxt = (r_op == OP_MUL) ? ST_ISSUE : ST_EXEC;
      ST_EXEC:    w_state_nxt = ST_SHOW;
      ST_ISSUE:   w_state_nxt = ST_WAIT;
      ST_WAIT:    if (w_mc_done || w_timeout) w_state_nxt = ST_SHOW;
      ST_SHOW:    if (w_any) w_state_nxt = ST_ENTER_A;
      default:    w_state_nxt = ST_ENTER_A;
    endcase
  end

  always_comb begin
    MC_Start    = (r_state == ST_ISSUE);
    SEVENSEGHEX = (r_state == ST_SHOW) ? r_res : 32'(DIP);
    w_led7      = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    w_led6      = (r_state == ST_SHOW);
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= OP_ADD;
      r_res       <= '0;
      r_led0      <= 1'b0;
      r_led1      <= 1'b0;
      r_wdog      <= '0;
      r_seen_busy <= 1'b0;
    end else begin
      case (r_state)
        ST_ENTER_A: if (w_any) begin
          r_a  <= DIP;
          r_op <= w_sel;
        end
        ST_ENTER_B: if (w_any) r_b <= DIP;
        ST_EXEC: begin
          r_res  <= 32'(w_sum);
          r_led0 <= w_sum[N_DIPs];
        end
        ST_ISSUE: begin
          r_wdog      <= '0;
          r_seen_busy <= 1'b0;
        end
        ST_WAIT: begin
          if (r_wdog != '1) r_wdog <= r_wdog + WD_W'(1);
          if (MC_Busy)      r_seen_busy <= 1'b1;
          if (w_mc_done) begin
            r_res <= MC_Result1;
          end else if (w_timeout) begin
            r_res  <= ERR_PATTERN;
            r_led1 <= 1'b1;
          end
        end
        ST_SHOW: if (w_any) begin
          r_led0 <= 1'b0;
          r_led1 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign LED_OUT     = N_LEDs_OUT'({w_led7, w_led6, 4'b0000, r_led1, r_led0});
  assign MC_Op       = MC_OP_MULU;
  assign MC_Operand1 = 32'(r_a);
  assign MC_Operand2 = 32'(r_b);

endmodule
`default_nettype wire
